// File: rtl/hpi_pkg.sv
// Register map and STATUS bit layout of the 16-bit host-port interface.
package hpi_pkg;

    typedef logic [15:0] hpi_word_t;

    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    localparam int STAT_MBX_OUT_FULL = 0;
    localparam int STAT_MBX_IN_FULL  = 1;
    localparam int STAT_OVF          = 2;

    function automatic hpi_word_t status_word(input logic ovf, input logic in_full,
                                              input logic out_full);
        hpi_word_t w;
        w                    = '0;
        w[STAT_OVF]          = ovf;
        w[STAT_MBX_IN_FULL]  = in_full;
        w[STAT_MBX_OUT_FULL] = out_full;
        return w;
    endfunction

endpackage

// File: rtl/hpi_ram.sv
// Single-port word RAM behind the DATA register; read port only updates when
// re is high so the last read word stays on the output between accesses.
module hpi_ram
    import hpi_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  hpi_word_t         wdata,
    output hpi_word_t         rdata
);

    hpi_word_t mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/hpi_responder.sv
// HPI register responder: strobe edge detection, auto-incrementing address
// pointer, two mailboxes with flags, and the registered read mux.
module hpi_responder
    import hpi_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        hpi_reset_n,
    input  logic [1:0]  hpi_addr,
    input  logic        hpi_cs_n,
    input  logic        hpi_rd_n,
    input  logic        hpi_wr_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    input  logic [15:0] dev_mbx_wdata,
    input  logic        dev_mbx_we,
    output logic [15:0] dev_mbx_rdata,
    output logic        dev_mbx_valid,
    input  logic        dev_mbx_ack,
    output logic        hpi_int
);

    logic      wr_act, rd_act, rd_eff, soft_rst;
    logic      wr_prev_reg, rd_prev_reg, rd_open_reg;
    logic [1:0] rd_sel_reg;
    logic      wr_rise, rd_rise, rd_rel;
    logic      host_wr_data, host_wr_addr, host_wr_mbx;
    logic      rel_data, rel_mbx, rel_status;

    hpi_word_t addr_reg;
    hpi_word_t mbx_in_reg, mbx_out_reg;
    logic      mbx_in_full_reg, mbx_out_full_reg, ovf_reg;
    hpi_word_t data_out_reg;
    logic      out_ram_reg;
    hpi_word_t ram_rdata;
    logic      addr_unused;

    assign wr_act   = !hpi_cs_n && !hpi_wr_n;
    assign rd_act   = !hpi_cs_n && !hpi_rd_n;
    assign rd_eff   = rd_act && !wr_act;
    assign soft_rst = !hpi_reset_n;

    assign wr_rise = wr_act && !wr_prev_reg;
    assign rd_rise = rd_eff && !rd_prev_reg;
    assign rd_rel  = rd_open_reg && !rd_eff;

    assign host_wr_data = wr_rise && (hpi_addr == HPI_DATA);
    assign host_wr_addr = wr_rise && (hpi_addr == HPI_ADDRESS);
    assign host_wr_mbx  = wr_rise && (hpi_addr == HPI_MAILBOX);
    assign rel_data     = rd_rel && (rd_sel_reg == HPI_DATA);
    assign rel_mbx      = rd_rel && (rd_sel_reg == HPI_MAILBOX);
    assign rel_status   = rd_rel && (rd_sel_reg == HPI_STATUS);

    // Byte-address bit 0 and bits above the RAM index are kept in addr_reg
    // for readback only.
    assign addr_unused = ^{addr_reg[15:ADDR_W+1], addr_reg[0]};

    // prev regs come out of reset high so a strobe held across reset is not
    // seen as a fresh edge; rd_open marks a read whose release must act.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_prev_reg <= 1'b1;
            rd_prev_reg <= 1'b1;
            rd_open_reg <= 1'b0;
            rd_sel_reg  <= HPI_DATA;
        end else begin
            wr_prev_reg <= wr_act;
            rd_prev_reg <= rd_eff;
            if (rd_rise) begin
                rd_sel_reg <= hpi_addr;
            end
            if (soft_rst) begin
                rd_open_reg <= 1'b0;
            end else if (rd_rise) begin
                rd_open_reg <= 1'b1;
            end else if (!rd_eff) begin
                rd_open_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            addr_reg <= '0;
        end else if (soft_rst) begin
            addr_reg <= '0;
        end else if (host_wr_addr) begin
            addr_reg <= hpi_data_in;
        end else if (host_wr_data || rel_data) begin
            addr_reg <= addr_reg + 16'd2;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mbx_in_reg       <= '0;
            mbx_out_reg      <= '0;
            mbx_in_full_reg  <= 1'b0;
            mbx_out_full_reg <= 1'b0;
            ovf_reg          <= 1'b0;
        end else if (soft_rst) begin
            mbx_in_reg       <= '0;
            mbx_out_reg      <= '0;
            mbx_in_full_reg  <= 1'b0;
            mbx_out_full_reg <= 1'b0;
            ovf_reg          <= 1'b0;
        end else begin
            // A device load beats a host read release of the same mailbox.
            if (dev_mbx_we) begin
                mbx_out_reg      <= dev_mbx_wdata;
                mbx_out_full_reg <= 1'b1;
            end else if (rel_mbx) begin
                mbx_out_full_reg <= 1'b0;
            end
            // A host write beats a device ack; the ack suppresses overflow.
            if (host_wr_mbx) begin
                mbx_in_reg      <= hpi_data_in;
                mbx_in_full_reg <= 1'b1;
            end else if (dev_mbx_ack) begin
                mbx_in_full_reg <= 1'b0;
            end
            if (host_wr_mbx && mbx_in_full_reg && !dev_mbx_ack) begin
                ovf_reg <= 1'b1;
            end else if (rel_status) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            data_out_reg <= '0;
            out_ram_reg  <= 1'b0;
        end else if (soft_rst) begin
            data_out_reg <= '0;
            out_ram_reg  <= 1'b0;
        end else if (rd_eff) begin
            out_ram_reg <= (hpi_addr == HPI_DATA);
            case (hpi_addr)
                HPI_MAILBOX: data_out_reg <= mbx_out_reg;
                HPI_ADDRESS: data_out_reg <= addr_reg;
                HPI_STATUS:  data_out_reg <= status_word(ovf_reg, mbx_in_full_reg,
                                                         mbx_out_full_reg);
                default:     data_out_reg <= data_out_reg;
            endcase
        end
    end

    // The RAM output register serves DATA reads directly, which gives a
    // valid word from the second strobe cycle with one cycle of RAM latency.
    hpi_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk_clk),
        .we    (host_wr_data && !soft_rst),
        .re    (rd_eff),
        .addr  (addr_reg[ADDR_W:1]),
        .wdata (hpi_data_in),
        .rdata (ram_rdata)
    );

    assign hpi_data_out  = out_ram_reg ? ram_rdata : data_out_reg;
    assign dev_mbx_rdata = mbx_in_reg;
    assign dev_mbx_valid = mbx_in_full_reg;
    assign hpi_int       = mbx_out_full_reg;

endmodule

// File: tb/tb_hpi_responder.sv
// Scoreboard bench for hpi_responder: directed scenarios plus randomized host
// and device traffic checked against a behavioural register/RAM model.
module tb_hpi_responder;
    import hpi_pkg::*;

    localparam int ADDR_W = 12;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        hpi_reset_n = 1'b1;
    logic [1:0]  hpi_addr = 2'd0;
    logic        hpi_cs_n = 1'b1;
    logic        hpi_rd_n = 1'b1;
    logic        hpi_wr_n = 1'b1;
    logic [15:0] hpi_data_in = 16'h0;
    logic [15:0] hpi_data_out;
    logic [15:0] dev_mbx_wdata = 16'h0;
    logic        dev_mbx_we = 1'b0;
    logic [15:0] dev_mbx_rdata;
    logic        dev_mbx_valid;
    logic        dev_mbx_ack = 1'b0;
    logic        hpi_int;

    always #5 clk_clk = ~clk_clk;

    hpi_responder #(.ADDR_W(ADDR_W)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .hpi_reset_n   (hpi_reset_n),
        .hpi_addr      (hpi_addr),
        .hpi_cs_n      (hpi_cs_n),
        .hpi_rd_n      (hpi_rd_n),
        .hpi_wr_n      (hpi_wr_n),
        .hpi_data_in   (hpi_data_in),
        .hpi_data_out  (hpi_data_out),
        .dev_mbx_wdata (dev_mbx_wdata),
        .dev_mbx_we    (dev_mbx_we),
        .dev_mbx_rdata (dev_mbx_rdata),
        .dev_mbx_valid (dev_mbx_valid),
        .dev_mbx_ack   (dev_mbx_ack),
        .hpi_int       (hpi_int)
    );

    // Scoreboard: kind 0 = hpi_data_out, 1 = dev_mbx_rdata, 2 = dev_mbx_valid, 3 = hpi_int
    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    logic sample_strobe = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model
    logic [15:0] m_mem [int];
    logic [15:0] m_addr = 16'h0;
    logic [15:0] m_mbx_in = 16'h0;
    logic [15:0] m_mbx_out = 16'h0;
    int          m_in_full = 0;
    int          m_out_full = 0;
    int          m_ovf = 0;

    function automatic int idx(input logic [15:0] a);
        return int'(a[ADDR_W:1]);
    endfunction

    function automatic logic [15:0] m_status();
        return 16'(m_ovf * 4 + m_in_full * 2 + m_out_full);
    endfunction

    function automatic logic [15:0] actual_of(input int kind);
        case (kind)
            0:       return hpi_data_out;
            1:       return dev_mbx_rdata;
            2:       return {15'h0, dev_mbx_valid};
            default: return {15'h0, hpi_int};
        endcase
    endfunction

    always @(negedge clk_clk) begin : monitor
        exp_t        e;
        logic [15:0] act;
        if (sample_strobe) begin
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = actual_of(e.kind);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end else begin
                    $display("ok   %s: %h", e.name, act);
                end
            end
        end
    end

    task automatic push(input int kind, input logic [15:0] v, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic check_now();
        if (sb_q.size() > 0) begin
            sample_strobe = 1'b1;
            @(negedge clk_clk);
            #1;
            sample_strobe = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_addr = 16'h0; m_mbx_in = 16'h0; m_mbx_out = 16'h0;
        m_in_full = 0; m_out_full = 0; m_ovf = 0;
    endtask

    task automatic push_all_zero(input string name);
        push(0, 16'h0, {name, "_data_out"});
        push(1, 16'h0, {name, "_mbx_rdata"});
        push(2, 16'h0, {name, "_mbx_valid"});
        push(3, 16'h0, {name, "_int"});
    endtask

    task automatic check_dev(input string name);
        push(1, m_mbx_in, {name, "_mbx_rdata"});
        push(2, 16'(m_in_full), {name, "_mbx_valid"});
        push(3, 16'(m_out_full), {name, "_int"});
        check_now();
    endtask

    task automatic host_write(input logic [1:0] sel, input logic [15:0] d, input bit ack_coll);
        @(posedge clk_clk); #1;
        hpi_addr = sel; hpi_data_in = d; hpi_cs_n = 1'b0; hpi_wr_n = 1'b0;
        if (ack_coll) dev_mbx_ack = 1'b1;
        case (sel)
            HPI_ADDRESS: m_addr = d;
            HPI_DATA: begin
                m_mem[idx(m_addr)] = d;
                m_addr = m_addr + 16'd2;
            end
            HPI_MAILBOX: begin
                if (m_in_full != 0 && !ack_coll) m_ovf = 1;
                m_mbx_in  = d;
                m_in_full = 1;
            end
            default: ;
        endcase
        @(posedge clk_clk); #1;
        dev_mbx_ack = 1'b0;
        @(posedge clk_clk); #1;
        hpi_cs_n = 1'b1; hpi_wr_n = 1'b1;
    endtask

    task automatic host_read(input logic [1:0] sel, input bit we_coll,
                             input logic [15:0] coll_d, input string name);
        logic [15:0] e;
        bit          known;
        @(posedge clk_clk); #1;
        hpi_addr = sel; hpi_cs_n = 1'b0; hpi_rd_n = 1'b0;
        known = 1'b1;
        case (sel)
            HPI_DATA: begin
                known = m_mem.exists(idx(m_addr));
                e = known ? m_mem[idx(m_addr)] : 16'h0;
            end
            HPI_MAILBOX: e = m_mbx_out;
            HPI_ADDRESS: e = m_addr;
            default:     e = m_status();
        endcase
        @(posedge clk_clk); #1;
        if (known) push(0, e, name);
        check_now();
        @(posedge clk_clk); #1;
        hpi_cs_n = 1'b1; hpi_rd_n = 1'b1;
        if (we_coll) begin
            dev_mbx_wdata = coll_d;
            dev_mbx_we    = 1'b1;
        end
        case (sel)
            HPI_DATA:    m_addr = m_addr + 16'd2;
            HPI_MAILBOX: m_out_full = 0;
            HPI_STATUS:  m_ovf = 0;
            default: ;
        endcase
        if (we_coll) begin
            m_mbx_out  = coll_d;
            m_out_full = 1;
        end
        @(posedge clk_clk); #1;
        dev_mbx_we = 1'b0;
        if (known) push(0, e, {name, "_hold"});
        check_now();
    endtask

    task automatic dev_write(input logic [15:0] d);
        @(posedge clk_clk); #1;
        dev_mbx_wdata = d; dev_mbx_we = 1'b1;
        m_mbx_out = d; m_out_full = 1;
        @(posedge clk_clk); #1;
        dev_mbx_we = 1'b0;
    endtask

    task automatic dev_ack_pulse();
        @(posedge clk_clk); #1;
        dev_mbx_ack = 1'b1;
        m_in_full = 0;
        @(posedge clk_clk); #1;
        dev_mbx_ack = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = 16'h0500 + 16'($urandom_range(0, 15)) * 16'd2 + 16'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) a = a ^ 16'hE000;
        return a;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset state
        repeat (2) @(posedge clk_clk);
        #1;
        push_all_zero("reset");
        check_now();
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b1;

        // Address auto-increment through writes and reads
        host_write(HPI_ADDRESS, 16'h0500, 0);
        host_write(HPI_DATA, 16'h1234, 0);
        host_write(HPI_DATA, 16'hABCD, 0);
        host_write(HPI_ADDRESS, 16'h0500, 0);
        host_read(HPI_DATA, 0, 16'h0, "data_rd0");
        host_read(HPI_DATA, 0, 16'h0, "data_rd1");
        host_read(HPI_ADDRESS, 0, 16'h0, "addr_0504");

        // Wrap of the 16-bit address and aliasing of the RAM index
        host_write(HPI_ADDRESS, 16'hFFFE, 0);
        host_write(HPI_DATA, 16'h5A5A, 0);
        host_read(HPI_ADDRESS, 0, 16'h0, "addr_wrap");
        host_write(HPI_ADDRESS, 16'h1FFE, 0);
        host_read(HPI_DATA, 0, 16'h0, "alias_1ffe");

        // Host-to-device mailbox and overflow
        host_write(HPI_MAILBOX, 16'h0011, 0);
        check_dev("mbx_in_first");
        host_write(HPI_MAILBOX, 16'h0022, 0);
        host_read(HPI_STATUS, 0, 16'h0, "status_ovf");
        host_read(HPI_STATUS, 0, 16'h0, "status_ovf_clr");

        // Device-to-host mailbox
        dev_ack_pulse();
        dev_write(16'hBEEF);
        check_dev("dev_we_beef");
        host_read(HPI_STATUS, 0, 16'h0, "status_out_full");
        host_read(HPI_MAILBOX, 0, 16'h0, "mbx_out_beef");
        check_dev("mbx_out_released");

        // Device load coinciding with a MAILBOX read release
        dev_write(16'h1111);
        host_read(HPI_MAILBOX, 1, 16'h2222, "mbx_coll_rd");
        check_dev("mbx_coll_int");
        host_read(HPI_MAILBOX, 0, 16'h0, "mbx_coll_new");
        check_dev("mbx_coll_cleared");

        // Device ack coinciding with a host MAILBOX write
        host_write(HPI_MAILBOX, 16'h0033, 0);
        host_write(HPI_MAILBOX, 16'h0044, 1);
        host_read(HPI_STATUS, 0, 16'h0, "status_ack_coll");
        check_dev("ack_coll");

        // Asynchronous reset in the middle of a held DATA read
        dev_write(16'h7777);
        host_write(HPI_ADDRESS, 16'h0500, 0);
        @(posedge clk_clk); #1;
        hpi_addr = HPI_DATA; hpi_cs_n = 1'b0; hpi_rd_n = 1'b0;
        @(posedge clk_clk); #3;
        reset_reset_n = 1'b0;
        model_reset();
        #1;
        push_all_zero("async_rst");
        check_now();
        @(posedge clk_clk); #1;
        reset_reset_n = 1'b1;
        repeat (2) @(posedge clk_clk);
        #1;
        hpi_cs_n = 1'b1; hpi_rd_n = 1'b1;
        host_read(HPI_ADDRESS, 0, 16'h0, "addr_after_rst");
        host_write(HPI_ADDRESS, 16'h0500, 0);
        host_read(HPI_DATA, 0, 16'h0, "ram_kept");

        // Host soft reset
        host_write(HPI_MAILBOX, 16'h00AA, 0);
        dev_write(16'h5555);
        host_read(HPI_STATUS, 0, 16'h0, "status_pre_soft");
        @(posedge clk_clk); #1;
        hpi_reset_n = 1'b0;
        model_reset();
        @(posedge clk_clk); #1;
        hpi_reset_n = 1'b1;
        push_all_zero("soft_rst");
        check_now();
        host_read(HPI_ADDRESS, 0, 16'h0, "addr_after_soft");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 10))
                0:       host_write(HPI_ADDRESS, rand_addr(), 0);
                1, 2:    host_write(HPI_DATA, 16'($urandom), 0);
                3, 4:    host_read(HPI_DATA, 0, 16'h0, "rnd_data");
                5:       host_write(HPI_MAILBOX, 16'($urandom), $urandom_range(0, 3) == 0);
                6:       host_read(HPI_MAILBOX, $urandom_range(0, 3) == 0, 16'($urandom), "rnd_mbx");
                7:       host_read(HPI_STATUS, 0, 16'h0, "rnd_status");
                8: begin
                    if ($urandom_range(0, 1) == 1) dev_write(16'($urandom));
                    else dev_ack_pulse();
                    check_dev("rnd_dev");
                end
                9:       host_read(HPI_ADDRESS, 0, 16'h0, "rnd_addr");
                default: host_write(HPI_STATUS, 16'($urandom), 0);
            endcase
        end

        repeat (2) @(posedge clk_clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hpi_responder.md
# hpi_responder

Synthesizable responder for the 16-bit OTG host-port interface (HPI) that the Nios PIO bank drives. It decodes the address, chip-select, read, write and reset strobes and answers with the DATA, MAILBOX, ADDRESS and STATUS register semantics, backed by an internal word RAM. It stands in for the USB controller's HPI port in simulation and on-board loopback builds, so the keyboard driver software runs unmodified against fabric logic. A small device-side mailbox port lets local logic or a bench exchange words with the host.

## Interface
- `ADDR_W`, default 12: word-address width of the backing RAM (4096 × 16).
- `clk_clk` input, 1: single clock, shared with the Nios PIO.
- `reset_reset_n` input, 1: asynchronous, active-low reset.
- `hpi_reset_n` input, 1: host-driven soft reset, active-low, sampled synchronously.
- `hpi_addr` input, 2: register select. 0 = DATA, 1 = MAILBOX, 2 = ADDRESS, 3 = STATUS.
- `hpi_cs_n` input, 1: chip select, active-low.
- `hpi_rd_n` input, 1: read strobe, active-low.
- `hpi_wr_n` input, 1: write strobe, active-low.
- `hpi_data_in` input, 16: write data from the host.
- `hpi_data_out` output, 16: read data to the host.
- `dev_mbx_wdata` input, 16: device-to-host mailbox data.
- `dev_mbx_we` input, 1: one-cycle pulse that loads `mbx_out`.
- `dev_mbx_rdata` output, 16: last host-written mailbox word.
- `dev_mbx_valid` output, 1: `mbx_in` holds an unconsumed word.
- `dev_mbx_ack` input, 1: device consumed `mbx_in`; clears `dev_mbx_valid`.
- `hpi_int` output, 1: high while `mbx_out` is full.

## Operation
- Strobes are synchronous to `clk_clk`. No synchronizers are used.
- `wr_act` = !cs_n & !wr_n. `rd_act` = !cs_n & !rd_n. Both asserted at once is illegal; in that case write wins and no read side effect occurs.
- A write commits on the first cycle of `wr_act` (rising edge of `wr_act`).
- Read side effects occur on the cycle after `rd_act` deasserts (release edge).
- ADDRESS write: `addr_reg` ← `hpi_data_in` (byte address). RAM word index = `addr_reg[ADDR_W:1]`. Bit 0 is ignored. Address bits above `ADDR_W` are stored but unused.
- ADDRESS read: returns `addr_reg`.
- DATA write: RAM[index] ← `hpi_data_in`, then `addr_reg` += 2.
- DATA read: returns RAM[index]. On release, `addr_reg` += 2.
- `addr_reg` wraps modulo 2^16. The RAM index therefore wraps modulo 2^ADDR_W.
- MAILBOX write: `mbx_in` ← data and `mbx_in_full` ← 1. If `mbx_in_full` was already 1, `ovf` ← 1 and the data is still overwritten.
- MAILBOX read: returns `mbx_out`. On release, `mbx_out_full` ← 0.
- STATUS read returns {13'b0, `ovf`, `mbx_in_full`, `mbx_out_full`}. On release, `ovf` ← 0. STATUS write is ignored.
- `dev_mbx_we`: `mbx_out` ← `dev_mbx_wdata` and `mbx_out_full` ← 1. If it coincides with a MAILBOX read release, the set wins.
- `dev_mbx_ack` clears `mbx_in_full`. If it coincides with a host MAILBOX write, the set wins and `ovf` is not raised.
- `dev_mbx_valid` = `mbx_in_full`. `hpi_int` = `mbx_out_full`.
- `hpi_reset_n` low (synchronous) clears `addr_reg`, both mailboxes, all flags and `hpi_data_out`. RAM contents are kept.
- `reset_reset_n` low does the same asynchronously, including in the middle of a strobe. After reset, a strobe that is still held is not treated as a new edge until it deasserts.

## Timing
- Reset values: `hpi_data_out` = 0, `dev_mbx_rdata` = 0, `dev_mbx_valid` = 0, `hpi_int` = 0.
- `hpi_data_out` is registered. It is valid from the 2nd cycle of `rd_act` and stays valid until release.
- When `rd_act` is low, `hpi_data_out` holds its last value.
- The RAM is synchronous-read with 1-cycle latency, addressed by the current `addr_reg` every cycle. A DATA read issued in the cycle right after an ADDRESS write or an increment is still valid from its 2nd cycle.
- The host must hold each strobe for at least 2 cycles and leave at least 1 idle cycle between accesses. The PIO software always does this.
- Mailbox flags update on the clock edge after the triggering event.

## Structure
- Package `hpi_pkg`:
  - register-select constants `HPI_DATA`, `HPI_MAILBOX`, `HPI_ADDRESS`, `HPI_STATUS`;
  - STATUS bit-position constants.
- Sub-module `hpi_ram`: single-port, synchronous write, 1-cycle synchronous read, depth 2^ADDR_W × 16, no reset. It must infer M9K block RAM.
- Top level contains:
  - strobe edge detectors;
  - `addr_reg`;
  - mailbox/flag registers;
  - output mux.

## Test plan
- Write ADDRESS = 0x0500, DATA 0x1234, DATA 0xABCD. Then ADDRESS = 0x0500 and two DATA reads → 0x1234, 0xABCD. ADDRESS readback → 0x0504.
- ADDRESS = 0xFFFE, DATA write 0x5A5A → `addr_reg` = 0x0000. ADDRESS = 0x1FFE (ADDR_W = 12) read → 0x5A5A, the same word as 0xFFFE.
- Host MAILBOX write 0x0011 → `dev_mbx_valid` = 1, `dev_mbx_rdata` = 0x0011. Second write 0x0022 without ack → STATUS = 0x0006. STATUS read again → 0x0002.
- `dev_mbx_we` with 0xBEEF → `hpi_int` = 1, STATUS = 0x0001. MAILBOX read → 0xBEEF. After release, `hpi_int` = 0.
- `dev_mbx_we` in the same cycle as a MAILBOX read release → `hpi_int` stays 1, `mbx_out` = new data.
- Assert `reset_reset_n` low during a held DATA read → all outputs 0. Releasing the held strobe causes no increment (ADDRESS reads 0x0000). Data written before reset is still readable.
